// File: rtl/handwriting_canvas_if.sv
// ---------------------------------------------------------------------------
// handwriting_canvas_if
//
// Groups every signal of the handwriting canvas except clock and reset.
//
//   editing            edit mode active
//   writing_block_pos  [4:0] block column, [8:5] block row being edited
//   mouse_x/mouse_y    pointer position in pixels
//   mouse_left         pen down
//   clear_req          single-cycle bitmap wipe request
//   h_cnt/v_cnt        VGA pixel counters
//   canvas_vga_pixel   bitmap bit under the VGA beam
//   rd_row/rd_data     registered row-read port (bit i = column i)
//   busy               clear in progress
//   dirty              bitmap written since the last clear
//   stroke_cnt         saturating pen-down event count since the last clear
//
// Modports: slave  = canvas side (drives the outputs)
//           master = system side (drives pointer, VGA counters, read row)
// ---------------------------------------------------------------------------
interface handwriting_canvas_if;
    logic        editing;
    logic [8:0]  writing_block_pos;
    logic [9:0]  mouse_x;
    logic [8:0]  mouse_y;
    logic        mouse_left;
    logic        clear_req;
    logic [9:0]  h_cnt;
    logic [8:0]  v_cnt;
    logic        canvas_vga_pixel;
    logic [4:0]  rd_row;
    logic [31:0] rd_data;
    logic        busy;
    logic        dirty;
    logic [7:0]  stroke_cnt;

    modport slave (
        input  editing,
        input  writing_block_pos,
        input  mouse_x,
        input  mouse_y,
        input  mouse_left,
        input  clear_req,
        input  h_cnt,
        input  v_cnt,
        input  rd_row,
        output canvas_vga_pixel,
        output rd_data,
        output busy,
        output dirty,
        output stroke_cnt
    );

    modport master (
        output editing,
        output writing_block_pos,
        output mouse_x,
        output mouse_y,
        output mouse_left,
        output clear_req,
        output h_cnt,
        output v_cnt,
        output rd_row,
        input  canvas_vga_pixel,
        input  rd_data,
        input  busy,
        input  dirty,
        input  stroke_cnt
    );
endinterface

// File: rtl/handwriting_canvas.sv
// ---------------------------------------------------------------------------
// handwriting_canvas
//
// Holds the 32x32 one-bit handwriting bitmap of the character block being
// edited. Mouse pen strokes inside the edited block set bits; the bitmap is
// served per pixel to the VGA pixel generator (combinational) and per row to
// a downstream consumer (registered, one cycle latency).
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    handwriting_canvas_if.slave (see the interface file for signals)
//
// Build option:
//   CANVAS_THICK_PEN_EN  when defined, a pen write sets the 3x3 neighbourhood
//                        around the pen pixel, clipped at the bitmap edges;
//                        otherwise only the pen pixel is set.
//
// A wipe (CLEAR state) zeroes one row per cycle for 32 cycles. It starts on
// clear_req or on the rising edge of editing, and cannot be restarted or
// aborted once running (only reset stops it).
// ---------------------------------------------------------------------------
module handwriting_canvas (
    input  logic                   clk,
    input  logic                   rst_n,
    handwriting_canvas_if.slave    bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic        clear_done;

    logic [4:0]  clr_row_reg;
    logic [31:0] bitmap_reg [0:31];
    logic        dirty_reg;
    logic [7:0]  stroke_cnt_reg;
    logic [31:0] rd_data_reg;
    logic        pen_prev_reg;
    logic        editing_prev_reg;

    logic        pointer_inside;
    logic [4:0]  px;
    logic [4:0]  py;
    logic        pen_write;
    logic        editing_rise;
    logic [31:0] col_mask;
    logic [31:0] row_hit;

    logic        beam_inside;
    logic [31:0] vga_row;

    // -----------------------------------------------------------------------
    // Pen qualification
    // -----------------------------------------------------------------------
    assign pointer_inside = (bus.mouse_x[9:5] == bus.writing_block_pos[4:0]) &&
                            (bus.mouse_y[8:5] == bus.writing_block_pos[8:5]);
    assign px = bus.mouse_x[4:0];
    assign py = bus.mouse_y[4:0];

    // Writes are refused while wiping so a held pen cannot survive a clear.
    assign pen_write    = bus.editing && bus.mouse_left && pointer_inside &&
                          (state_reg == IDLE);
    assign editing_rise = bus.editing && !editing_prev_reg;

    // -----------------------------------------------------------------------
    // Pen footprint: col_mask holds the columns touched, row_hit the rows.
    // -----------------------------------------------------------------------
`ifdef CANVAS_THICK_PEN_EN
    // Neighbour columns are guarded explicitly so that px-1 at column 0 and
    // px+1 at column 31 never wrap to the opposite edge.
    always_comb begin
        col_mask = 32'd1 << px;
        if (px != 5'd0) begin
            col_mask = col_mask | (32'd1 << (px - 5'd1));
        end
        if (px != 5'd31) begin
            col_mask = col_mask | (32'd1 << (px + 5'd1));
        end
    end

    for (genvar gi = 0; gi < 32; gi++) begin : g_row_hit
        assign row_hit[gi] = (py == 5'(gi)) ||
                             ((py != 5'd0)  && ((py - 5'd1) == 5'(gi))) ||
                             ((py != 5'd31) && ((py + 5'd1) == 5'(gi)));
    end
`else
    assign col_mask = 32'd1 << px;

    for (genvar gi = 0; gi < 32; gi++) begin : g_row_hit
        assign row_hit[gi] = (py == 5'(gi));
    end
`endif

    // -----------------------------------------------------------------------
    // Wipe state machine
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        clear_done = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.clear_req || editing_rise) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                if (clr_row_reg == 5'd31) begin
                    state_next = IDLE;
                    clear_done = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The row counter only advances while wiping; it wraps 31 -> 0 on the
    // final wipe edge, so it is already 0 for the next clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_row_reg <= 5'd0;
        end else if (state_reg == CLEAR) begin
            clr_row_reg <= clr_row_reg + 5'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Bitmap storage. A pen write that coincides with clear_req in IDLE still
    // lands; the wipe that follows removes it.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 32; r++) begin
                bitmap_reg[r] <= '0;
            end
        end else if (state_reg == CLEAR) begin
            bitmap_reg[clr_row_reg] <= '0;
        end else if (pen_write) begin
            for (int r = 0; r < 32; r++) begin
                if (row_hit[r]) begin
                    bitmap_reg[r] <= bitmap_reg[r] | col_mask;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Status: dirty flag, stroke counter, edge-detect history
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dirty_reg        <= 1'b0;
            stroke_cnt_reg   <= 8'd0;
            pen_prev_reg     <= 1'b0;
            editing_prev_reg <= 1'b0;
        end else begin
            pen_prev_reg     <= pen_write;
            editing_prev_reg <= bus.editing;

            if (clear_done) begin
                dirty_reg <= 1'b0;
            end else if (pen_write) begin
                dirty_reg <= 1'b1;
            end

            // A stroke is counted once per rising edge of the qualified pen,
            // so a held pen counts once and a pen held through a wipe is not
            // counted until it qualifies again.
            if (clear_done) begin
                stroke_cnt_reg <= 8'd0;
            end else if (pen_write && !pen_prev_reg && (stroke_cnt_reg != 8'hFF)) begin
                stroke_cnt_reg <= stroke_cnt_reg + 8'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registered row-read port
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= bitmap_reg[bus.rd_row];
        end
    end

    // -----------------------------------------------------------------------
    // Per-pixel display read: only inside the edited block while editing.
    // -----------------------------------------------------------------------
    assign beam_inside = bus.editing &&
                         (bus.h_cnt[9:5] == bus.writing_block_pos[4:0]) &&
                         (bus.v_cnt[8:5] == bus.writing_block_pos[8:5]);
    assign vga_row     = bitmap_reg[bus.v_cnt[4:0]];

    assign bus.canvas_vga_pixel = beam_inside && vga_row[bus.h_cnt[4:0]];
    assign bus.rd_data          = rd_data_reg;
    assign bus.busy             = (state_reg == CLEAR);
    assign bus.dirty            = dirty_reg;
    assign bus.stroke_cnt       = stroke_cnt_reg;

endmodule

// File: tb/tb_handwriting_canvas.sv
// ---------------------------------------------------------------------------
// tb_handwriting_canvas
//
// Self-checking bench for handwriting_canvas. A reference bitmap is kept in
// the bench and updated from the pointer coordinates; row reads are checked
// through a scoreboard queue. Pen strokes come from a vector table, wipe and
// reset corner cases from hand-written sequences.
// ---------------------------------------------------------------------------
module tb_handwriting_canvas;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    handwriting_canvas_if cif();

    handwriting_canvas dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (cif.slave)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [9:0] mx;
        logic [8:0] my;
        logic       exp_inside;
    } vec_t;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_pen(input int px, input int py);
`ifdef CANVAS_THICK_PEN_EN
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                if (py + dy >= 0 && py + dy < 32 && px + dx >= 0 && px + dx < 32) begin
                    model[py + dy][px + dx] = 1'b1;
                end
            end
        end
`else
        model[py][px] = 1'b1;
`endif
    endtask

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            model[r] = '0;
        end
    endtask

    task automatic read_row(input int r);
        sb_t item;
        cif.rd_row = 5'(r);
        sb_q.push_back('{$sformatf("row%0d", r), model[r]});
        tick();
        item = sb_q.pop_front();
        check(item.name, cif.rd_data, item.exp);
    endtask

    task automatic read_all_rows();
        for (int r = 0; r < 32; r++) begin
            read_row(r);
        end
    endtask

    // Counts consecutive samples with busy high, starting with the current
    // one; bounded so a stuck busy cannot hang the run.
    task automatic count_busy(output int n);
        n = 0;
        for (int g = 0; g < 40; g++) begin
            if (!cif.busy) break;
            n++;
            tick();
        end
    endtask

    initial begin
        int n;
        int exp_stroke;
        logic exp_dirty;

        vecs[0] = '{10'd100, 9'd40, 1'b1};   // local (4,8)
        vecs[1] = '{10'd96,  9'd32, 1'b1};   // local (0,0) corner
        vecs[2] = '{10'd127, 9'd63, 1'b1};   // local (31,31) corner
        vecs[3] = '{10'd110, 9'd50, 1'b1};   // local (14,18)
        vecs[4] = '{10'd200, 9'd40, 1'b0};   // wrong block column
        vecs[5] = '{10'd100, 9'd70, 1'b0};   // wrong block row

        cif.editing           = 1'b1;
        cif.writing_block_pos = 9'h023;
        cif.mouse_x           = '0;
        cif.mouse_y           = '0;
        cif.mouse_left        = 1'b0;
        cif.clear_req         = 1'b0;
        cif.h_cnt             = '0;
        cif.v_cnt             = '0;
        cif.rd_row            = '0;
        model_clear();

        // ---- reset with editing high -> automatic wipe -------------------
        #12;
        check("reset_busy",   32'(cif.busy),       32'd0);
        check("reset_dirty",  32'(cif.dirty),      32'd0);
        check("reset_stroke", 32'(cif.stroke_cnt), 32'd0);
        check("reset_rd",     cif.rd_data,         32'd0);
        rst_n = 1'b1;
        tick();
        count_busy(n);
        check("auto_clear_cycles", 32'(n), 32'd32);
        check("auto_clear_dirty",  32'(cif.dirty),      32'd0);
        check("auto_clear_stroke", 32'(cif.stroke_cnt), 32'd0);
        read_all_rows();

        // ---- table-driven pen strokes -------------------------------------
        exp_stroke = 0;
        exp_dirty  = 1'b0;
        foreach (vecs[i]) begin
            int px;
            int py;
            px = int'(vecs[i].mx[4:0]);
            py = int'(vecs[i].my[4:0]);
            cif.mouse_x    = vecs[i].mx;
            cif.mouse_y    = vecs[i].my;
            cif.h_cnt      = vecs[i].mx;
            cif.v_cnt      = vecs[i].my;
            cif.mouse_left = 1'b1;
            tick();
            if (vecs[i].exp_inside) begin
                model_pen(px, py);
                exp_stroke++;
                exp_dirty = 1'b1;
            end
            check($sformatf("vec%0d_pix", i), 32'(cif.canvas_vga_pixel), 32'(vecs[i].exp_inside));
            cif.mouse_left = 1'b0;
            tick();
            check($sformatf("vec%0d_stroke", i), 32'(cif.stroke_cnt), 32'(exp_stroke));
            check($sformatf("vec%0d_dirty", i),  32'(cif.dirty),      32'(exp_dirty));
            read_row((py + 31) % 32);
            read_row(py);
            read_row((py + 1) % 32);
        end

        // ---- bitmap follows the block position ----------------------------
        cif.writing_block_pos = 9'h000;
        cif.h_cnt = 10'd4;
        cif.v_cnt = 9'd8;
        #1;
        check("follow_pos_pix", 32'(cif.canvas_vga_pixel), 32'(model[8][4]));
        cif.writing_block_pos = 9'h023;

        // ---- wipe with the pen held and a repeated clear_req --------------
        cif.mouse_x = 10'd100;
        cif.mouse_y = 9'd40;
        cif.clear_req = 1'b1;
        tick();
        cif.clear_req = 1'b0;
        n = 0;
        for (int c = 1; c <= 40; c++) begin
            if (!cif.busy) break;
            n++;
            cif.mouse_left = (c >= 5 && c <= 10);
            cif.clear_req  = (c == 12);
            tick();
        end
        cif.mouse_left = 1'b0;
        cif.clear_req  = 1'b0;
        model_clear();
        check("pen_in_clear_cycles", 32'(n), 32'd32);
        check("pen_in_clear_stroke", 32'(cif.stroke_cnt), 32'd0);
        check("pen_in_clear_dirty",  32'(cif.dirty),      32'd0);
        read_all_rows();

        // ---- simultaneous pen write and clear_req -------------------------
        cif.h_cnt = 10'd100;
        cif.v_cnt = 9'd40;
        cif.mouse_left = 1'b1;
        cif.clear_req  = 1'b1;
        tick();
        cif.mouse_left = 1'b0;
        cif.clear_req  = 1'b0;
        check("simul_pix_landed", 32'(cif.canvas_vga_pixel), 32'd1);
        check("simul_busy",       32'(cif.busy),             32'd1);
        count_busy(n);
        check("simul_clear_cycles", 32'(n), 32'd32);
        check("simul_pix_wiped",    32'(cif.canvas_vga_pixel), 32'd0);
        check("simul_stroke",       32'(cif.stroke_cnt),       32'd0);
        read_row(8);

        // ---- 300 strokes saturate the counter -----------------------------
        for (int i = 0; i < 300; i++) begin
            cif.mouse_left = 1'b1;
            tick();
            cif.mouse_left = 1'b0;
            tick();
        end
        model_pen(4, 8);
        check("sat_stroke", 32'(cif.stroke_cnt), 32'd255);
        check("sat_dirty",  32'(cif.dirty),      32'd1);

        // ---- pen held outside the block ------------------------------------
        cif.mouse_x = 10'd300;
        cif.mouse_y = 9'd200;
        cif.h_cnt   = 10'd300;
        cif.v_cnt   = 9'd200;
        cif.mouse_left = 1'b1;
        tick();
        tick();
        tick();
        check("outside_pix", 32'(cif.canvas_vga_pixel), 32'd0);
        cif.mouse_left = 1'b0;
        check("outside_stroke", 32'(cif.stroke_cnt), 32'd255);
        read_row(7);
        read_row(8);
        read_row(9);

        // ---- asynchronous reset in the middle of a wipe --------------------
        cif.clear_req = 1'b1;
        tick();
        cif.clear_req = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        check("mid_clear_busy", 32'(cif.busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",   32'(cif.busy),       32'd0);
        check("async_rst_dirty",  32'(cif.dirty),      32'd0);
        check("async_rst_stroke", 32'(cif.stroke_cnt), 32'd0);
        check("async_rst_rd",     cif.rd_data,         32'd0);
        cif.editing = 1'b0;
        #1;
        check("not_editing_pix", 32'(cif.canvas_vga_pixel), 32'd0);
        #10;
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", 32'(cif.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/handwriting_canvas.md
# handwriting_canvas

Stores the 32×32 one-bit handwriting bitmap for the character block currently being edited. It turns mouse pen strokes into set bits and serves the bitmap two ways: per pixel to the display pixel generator (`canvas_vga_pixel`), and per row to a downstream consumer such as a recognizer or commit logic. It sits directly upstream of the pixel generator, which overlays this bitmap inside the highlighted editing block.

## Interface
Parameters: none.

Ports:
- `clk` input 1: system clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `editing` input 1: edit mode active.
- `writing_block_pos` input 9: `[4:0]` is the block column and `[8:5]` is the block row of the block being edited.
- `mouse_x` input 10: pointer X in pixels.
- `mouse_y` input 9: pointer Y in pixels.
- `mouse_left` input 1: pen down (left button held).
- `clear_req` input 1: single-cycle pulse requesting a bitmap wipe.
- `h_cnt` input 10: VGA horizontal pixel counter.
- `v_cnt` input 9: VGA vertical pixel counter.
- `canvas_vga_pixel` output 1: bitmap bit at the current VGA pixel.
- `rd_row` input 5: row-read address.
- `rd_data` output 32: bitmap row `rd_row`; bit i is column i.
- `busy` output 1: high while a clear is in progress.
- `dirty` output 1: at least one bit has been written since the last clear.
- `stroke_cnt` output 8: pen-down events since the last clear, saturating.

## Operation
- Storage is `bitmap[0:31]`, 32 rows of 32 bits, held in flops. Row index is Y and bit index is X.
- The pointer is inside the block when `mouse_x[9:5]==writing_block_pos[4:0]` and `mouse_y[8:5]==writing_block_pos[8:5]`.
- Local pen coordinate: `px=mouse_x[4:0]`, `py=mouse_y[4:0]`.
- Pen write condition, evaluated every cycle: `editing && mouse_left && inside && state==IDLE`.
  - When the condition holds, set bit (px,py) and set `dirty`.
  - Bits are only ever set, never cleared, by pen writes.
- `stroke_cnt` increments on the rising edge of the pen write condition (previous cycle low, current cycle high). It saturates at 255.
- State machine, two states:
  - IDLE → CLEAR on a `clear_req` pulse, or on the rising edge of `editing` (automatic wipe when entering edit mode).
  - CLEAR: row counter `clr_row` starts at 0. Each cycle zeroes `bitmap[clr_row]` and increments the counter.
  - CLEAR → IDLE after row 31 is zeroed. On that same edge, `dirty` and `stroke_cnt` are cleared.
  - `busy = (state==CLEAR)`.
- `canvas_vga_pixel` is combinational.
  - Equals `bitmap[v_cnt[4:0]][h_cnt[4:0]]` when `editing` is high and `h_cnt[9:5]`/`v_cnt[8:5]` match `writing_block_pos`.
  - Otherwise 0.
- `rd_data` is registered: `rd_data <= bitmap[rd_row]` every cycle.
- Boundary and conflict rules:
  - `clear_req` or a rising `editing` edge during CLEAR is ignored; the clear does not restart.
  - Pen writes are dropped during CLEAR and are not queued.
  - A simultaneous pen write and `clear_req` in IDLE: the write lands, then CLEAR wipes it.
  - `editing` falling mid-clear does not abort the clear.
  - `writing_block_pos` changing does not clear the bitmap; the bitmap follows the new block position.
  - Pointer at block column/row 0 or 31 (the border pixels) is still writable. Whether border pixels are shown is the display's responsibility.

## Timing
- Reset (`rst_n` low, asynchronous): all bitmap bits 0, state IDLE, `clr_row`=0, `busy`=0, `dirty`=0, `stroke_cnt`=0, `rd_data`=0. The previous-cycle pen/edit registers are 0, so `editing` already high at reset release triggers an automatic clear.
- Pen write to `canvas_vga_pixel` latency: 1 cycle. The bit is visible on the cycle after the qualifying clock edge.
- Clear takes exactly 32 cycles with `busy` high.
  - `busy` rises on the edge after the `clear_req` cycle.
  - `busy` falls on the edge that zeroes row 31.
  - The first pen write can land on the following edge.
- `rd_data` latency: 1 cycle after `rd_row` changes.
- Reset asserted mid-clear: immediate return to the reset values listed above.

## Configuration
- `CANVAS_THICK_PEN_EN`
  - Defined: a pen write sets the 3×3 neighbourhood centred on (px,py), clipped at rows/columns 0 and 31 with no wrap-around.
  - Undefined: a pen write sets the single pixel (px,py).
  - All other behaviour is identical in both builds.

## Test plan
- Reset with `editing`=1 → `busy`=1 for 32 cycles; then `dirty`=0, `stroke_cnt`=0, all `rd_data` rows 0x00000000.
- Block pos 9'h023 (column 3, row 1), mouse (100,40), pen held 1 cycle → bitmap row 8 bit 4 set; `canvas_vga_pixel`=1 at h=100, v=40; `stroke_cnt`=1; `dirty`=1; row 8 reads 0x00000010.
- Thick build, pen at local (0,0) → rows 0–1 read 0x00000003, nothing wraps to row/column 31. Thin build, same stimulus → only row 0 bit 0 set.
- `clear_req` pulse, then pen held during cycles 5–10 of the clear → no bits set, `stroke_cnt` unchanged at 0 after the clear ends.
- 300 separate press/release pulses inside the block → `stroke_cnt`=255. Pen held with pointer outside the block → no bitmap change, and `canvas_vga_pixel`=0 at that pointer position.
- `rst_n` low at clear row 15 → `busy`=0 and all outputs at reset values immediately, without waiting for a clock edge.
